bits_to_symbols: RTL
====================

// Module: bits_to_symbols
// PURPOSE
//   Transmit-side mapper: accepts N-bit words, serializes MSB first and emits one
//   signed DATA_WIDTH-bit antipodal symbol per accepted beat (bit 1 -> +AMPLITUDE,
//   bit 0 -> -AMPLITUDE). Sits ahead of the channel model; the receive-side slicer
//   (threshold below AMPLITUDE) recovers the bit stream.
// PARAMETERS
//   N          8        bits per input word (N >= 1)
//   DATA_WIDTH 16       symbol width, two's complement
//   AMPLITUDE  16'd256  symbol magnitude; must be > 0 and < 2**(DATA_WIDTH-1)
// PORTS
//   clk         in   1           single clock, rising edge
//   rst_n       in   1           asynchronous, active-low reset
//   in_word     in   N           word to transmit; in_word[N-1] is sent first
//   in_valid    in   1           in_word valid
//   in_ready    out  1           mapper can accept a word this cycle
//   out_symbol  out  DATA_WIDTH  signed symbol
//   out_valid   out  1           out_symbol valid
//   out_ready   in   1           downstream accepts out_symbol this cycle
//   out_last    out  1           out_symbol carries bit 0 (LSB) of its word
// BEHAVIOUR
//   - Reset: out_symbol=0, out_valid=0, out_last=0, in_ready=1; FSM=IDLE, bit_cnt=0,
//     shift register cleared, differential state (if built) cleared.
//   - Handshakes are valid/ready; a transfer happens on a clk edge where both are 1.
//     out_symbol/out_last stay stable while out_valid=1 and out_ready=0.
//   - FSM IDLE: in_ready=1. On in_valid, capture in_word, register the MSB symbol,
//     out_valid=1, bit_cnt=N-1 -> SEND. Latency: word accepted at edge k gives its
//     first symbol valid after edge k (one register stage).
//   - FSM SEND: on each out transfer, shift and decrement bit_cnt. out_last=1 when
//     bit_cnt==0. in_ready = (bit_cnt==0) & out_ready (last beat completing).
//     Last beat + in_valid: load the new word, emit its MSB next cycle with no
//     bubble, stay in SEND. Last beat without in_valid: out_valid=0 -> IDLE.
//   - in_valid while busy and not on the last beat: not accepted, in_word ignored;
//     the sender must hold it.
//   - N=1: every symbol has out_last=1; back-to-back words stream at 1 symbol/cycle.
//   - Arithmetic: -AMPLITUDE is formed as the two's-complement negation in
//     DATA_WIDTH bits; out_symbol is never 0 while out_valid=1.
//   - rst_n asserted mid-word: word discarded, outputs return to reset values
//     immediately (asynchronously), no partial word resumes.
// CONFIGURATION
//   `B2S_DIFF_EN defined: differential (NRZI-style) encoding. Transmitted level
//     t = b XOR t_prev, where t_prev is the level of the previously transmitted
//     symbol. t_prev updates only on an out transfer, persists across words, and is
//     cleared (0 -> -AMPLITUDE reference) only by rst_n. The symbol is +AMPLITUDE
//     when t=1.
//   Undefined: direct mapping, t = b; no extra state.
// STRUCTURE
//   - Package b2s_pkg: FSM state enum (B2S_IDLE, B2S_SEND) and the default
//     AMPLITUDE/DATA_WIDTH constants shared with the receive-side slicer bench.
//   - One sub-module, b2s_diff_encoder (bit in, advance strobe, level out). It is
//     instantiated only under `B2S_DIFF_EN; otherwise the bit passes straight
//     through.
//   - The top level holds the FSM, the shift register, bit_cnt and the output
//     register.
// TESTING
//   1 Reset: hold rst_n=0 for 3 cycles -> out_valid=0, out_symbol=0, in_ready=1.
//   2 N=8, in_word=8'hA5, out_ready=1 -> out_symbol sequence +256,-256,+256,-256,
//     -256,+256,-256,+256; out_last only on the 8th symbol; then in_valid=0 ->
//     out_valid drops.
//   3 Backpressure: out_ready=0 for 5 cycles on the 3rd symbol of 8'hF0 -> symbol
//     +256 is held stable; the remaining sequence is unchanged and no beat is lost.
//   4 Back-to-back: 8'hFF then 8'h00, in_valid held high -> 16 consecutive valid
//     cycles (8x +256, 8x -256); in_ready=1 only on cycles 0 and 8.
//   5 Mid-word reset: pulse rst_n low after the 4th symbol of 8'h3C -> outputs reset
//     at once; the next word 8'h80 starts fresh: +256 followed by 7x -256.
//   6 `B2S_DIFF_EN, in_word=8'hA5 from reset -> levels 1,1,0,0,0,1,1,0, i.e.
//     +256,+256,-256,-256,-256,+256,+256,-256. Feeding these symbols to the
//     receive-side slicer and differentially decoding them returns 8'hA5.

Source files
------------

// File: rtl/b2s_pkg.sv
// ----------------------------------------------------------------------------
// b2s_pkg
//   Shared definitions for the bits_to_symbols transmit mapper and the
//   receive-side slicer bench.
//   - b2s_state_t     : mapper FSM states (B2S_IDLE, B2S_SEND)
//   - B2S_N           : default bits per input word
//   - B2S_DATA_WIDTH  : default symbol width (two's complement)
//   - B2S_AMPLITUDE   : default symbol magnitude
//   - b2s_cnt_width() : width of a down-counter that must hold N-1 (min 1 bit)
// ----------------------------------------------------------------------------
package b2s_pkg;

    localparam int                          B2S_N          = 8;
    localparam int                          B2S_DATA_WIDTH = 16;
    localparam logic [B2S_DATA_WIDTH-1:0]   B2S_AMPLITUDE  = 16'd256;

    typedef enum logic {
        B2S_IDLE = 1'b0,
        B2S_SEND = 1'b1
    } b2s_state_t;

    // A one-bit word still needs a one-bit counter.
    function automatic int b2s_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bits_to_symbols_if.sv
// ----------------------------------------------------------------------------
// bits_to_symbols_if
//   Word-in / symbol-out valid-ready bus of the bits_to_symbols mapper.
//   Signals:
//     in_word    [N]           word to transmit, in_word[N-1] sent first
//     in_valid                 in_word valid
//     in_ready                 mapper accepts a word this cycle
//     out_symbol [DATA_WIDTH]  signed antipodal symbol
//     out_valid                out_symbol valid
//     out_ready                downstream accepts out_symbol this cycle
//     out_last                 out_symbol carries the LSB of its word
//   Modports:
//     master : word source / symbol sink (drives in_*, out_ready)
//     slave  : the mapper
// ----------------------------------------------------------------------------
interface bits_to_symbols_if
    import b2s_pkg::*;
#(
    parameter int N          = B2S_N,
    parameter int DATA_WIDTH = B2S_DATA_WIDTH
);

    logic [N-1:0]                  in_word;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_WIDTH-1:0]  out_symbol;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;

    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_symbol, out_valid, out_last
    );

    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_symbol, out_valid, out_last
    );

endinterface

// File: rtl/b2s_diff_encoder.sv
// ----------------------------------------------------------------------------
// b2s_diff_encoder
//   NRZI-style differential encoder: o_level = i_bit XOR level of the previous
//   symbol. Only instantiated when B2S_DIFF_EN is defined.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset (level reference = 0)
//     i_bit       data bit of the symbol being registered
//     i_advance   a new symbol is registered this cycle; remember its level
//     o_level     transmitted level for i_bit
// ----------------------------------------------------------------------------
module b2s_diff_encoder (
    input  logic clk,
    input  logic rst_n,
    input  logic i_bit,
    input  logic i_advance,
    output logic o_level
);

    // Level of the most recently registered symbol. A registered symbol is
    // always transmitted before the next one, so this is t_prev for the next.
    logic r_level;

    assign o_level = i_bit ^ r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
        end else if (i_advance) begin
            r_level <= o_level;
        end
    end

endmodule

// File: rtl/bits_to_symbols.sv
// ----------------------------------------------------------------------------
// bits_to_symbols
//   Transmit mapper: accepts N-bit words, serializes them MSB first and emits
//   one antipodal symbol per beat (level 1 -> +AMPLITUDE, 0 -> -AMPLITUDE).
//   Macro B2S_DIFF_EN: when defined, levels are differentially encoded
//   (b2s_diff_encoder); otherwise the level is the data bit itself.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    bits_to_symbols_if.slave (word in, symbol out, valid/ready)
// ----------------------------------------------------------------------------
module bits_to_symbols
    import b2s_pkg::*;
#(
    parameter int                     N          = B2S_N,
    parameter int                     DATA_WIDTH = B2S_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]  AMPLITUDE  = DATA_WIDTH'(B2S_AMPLITUDE)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    bits_to_symbols_if.slave      bus
);

    localparam int                    CNT_W    = b2s_cnt_width(N);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(N - 1);
    localparam logic [DATA_WIDTH-1:0] SYM_POS  = AMPLITUDE;
    localparam logic [DATA_WIDTH-1:0] SYM_NEG  = ~AMPLITUDE + DATA_WIDTH'(1);

    b2s_state_t              r_state;
    b2s_state_t              w_state_next;
    logic [N-1:0]            r_shift;     // remaining bits, next one at [N-1]
    logic [CNT_W-1:0]        r_bit_cnt;   // bits still to send after current
    logic [DATA_WIDTH-1:0]   r_symbol;

    logic w_load;        // capture a new word, register its MSB symbol
    logic w_shift;       // current beat done, register the next bit
    logic w_drop;        // last beat done with nothing queued
    logic w_in_ready;
    logic w_last_beat;
    logic w_bit;
    logic w_level;
    logic w_advance;

    assign w_last_beat = (r_bit_cnt == '0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!rst_n) begin
            r_state <= B2S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned and no latch is inferred.
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_drop       = 1'b0;
        w_in_ready   = 1'b0;
        case (r_state)
            B2S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = B2S_SEND;
                end
            end
            B2S_SEND: begin
                // A new word may enter only while the last beat completes,
                // which lets words stream with no bubble.
                w_in_ready = w_last_beat & bus.out_ready;
                if (bus.out_ready) begin
                    if (!w_last_beat) begin
                        w_shift = 1'b1;
                    end else if (bus.in_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop       = 1'b1;
                        w_state_next = B2S_IDLE;
                    end
                end
            end
            default: w_state_next = B2S_IDLE;
        endcase
    end

    // ------------------------------------------------------ bit -> level
    assign w_bit     = w_load ? bus.in_word[N-1] : r_shift[N-1];
    assign w_advance = w_load | w_shift;

`ifdef B2S_DIFF_EN
    b2s_diff_encoder u_diff_encoder (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bit     (w_bit),
        .i_advance (w_advance),
        .o_level   (w_level)
    );
`else
    assign w_level = w_bit;
`endif

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_symbol  <= '0;
        end else if (w_load) begin
            r_shift   <= bus.in_word << 1;
            r_bit_cnt <= CNT_LAST;
            r_symbol  <= w_level ? SYM_POS : SYM_NEG;
        end else if (w_shift) begin
            r_shift   <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt - CNT_W'(1);
            r_symbol  <= w_level ? SYM_POS : SYM_NEG;
        end else if (w_drop) begin
            r_symbol  <= '0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == B2S_SEND);
    assign bus.out_symbol = r_symbol;
    assign bus.out_last   = (r_state == B2S_SEND) && w_last_beat;

endmodule
